dout_display: RTL and testbench

DOUT_DISPLAY -- requirements
Module: dout_display

---
 rtl/dout_display_pkg.sv | 52 +++++
 rtl/dout_display_if.sv | 29 ++
 rtl/dout_display_bin2bcd.sv | 42 ++++
 rtl/dout_display.sv | 160 ++++++++++++++++
 tb/tb_dout_display.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/dout_display_pkg.sv
// Shared definitions for the CPU output display: FSM encodings, segment glyphs,
// scan default and the double-dabble step used by the BCD converter.
package dout_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int SCAN_DIV_DEFAULT = 50000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a} glyph for a hex nibble
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // One double-dabble step: BCD field is [19:8], binary field is [7:0]
    function automatic logic [19:0] dd_step(input logic [19:0] sh);
        logic [19:0] adj;
        adj = sh;
        for (int n = 0; n < 3; n++) begin
            adj[8 + 4*n +: 4] = (adj[8 + 4*n +: 4] >= 4'd5) ? adj[8 + 4*n +: 4] + 4'd3
                                                             : adj[8 + 4*n +: 4];
        end
        return {adj[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/dout_display_if.sv
// CPU-to-display bus: data/valid/format inputs and the multiplexed LED outputs.
// Optional hex glyph select is present only when DOUT_DISPLAY_HEX_EN is defined.
interface dout_display_if;
    logic [7:0] din;
    logic       dval;
    logic       sgn;
`ifdef DOUT_DISPLAY_HEX_EN
    logic       hex;
`endif
    logic [6:0] seg;
    logic [3:0] anode;
    logic       busy;

    modport master (
        output din, dval, sgn,
`ifdef DOUT_DISPLAY_HEX_EN
        output hex,
`endif
        input  seg, anode, busy
    );

    modport slave (
        input  din, dval, sgn,
`ifdef DOUT_DISPLAY_HEX_EN
        input  hex,
`endif
        output seg, anode, busy
    );
endinterface

// File: rtl/dout_display_bin2bcd.sv
// Eight-step sequential double-dabble converter with start/done handshake.
module dout_display_bin2bcd
    import dout_display_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [8:0]  i_bin,
    output logic        o_done,
    output logic [11:0] o_bcd
);
    logic [19:0] r_sh;
    logic [2:0]  r_cnt;
    logic        r_active;
    logic        r_done;

    // Magnitude never exceeds 255, so i_bin[8] is always 0 and loads as a harmless zero
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh     <= 20'd0;
            r_cnt    <= 3'd0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_sh     <= {11'd0, i_bin};
            r_cnt    <= 3'd0;
            r_active <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_active) begin
            r_sh     <= dd_step(r_sh);
            r_cnt    <= r_cnt + 3'd1;
            r_active <= (r_cnt != 3'd7);
            r_done   <= (r_cnt == 3'd7);
        end else begin
            r_done   <= 1'b0;
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_sh[19:8];

endmodule

// File: rtl/dout_display.sv
// Four-digit multiplexed decimal display of the CPU output word.
// Build option DOUT_DISPLAY_HEX_EN adds a hex glyph mode that skips conversion.
module dout_display
    import dout_display_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic          i_clock,
    input  logic          i_reset,
    dout_display_if.slave bus
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_step;
    logic             r_neg;
    logic             r_hex;
    logic [7:0]       r_din;
    logic [3:0][6:0]  r_disp;
    logic [3:0][6:0]  w_result;
    logic             r_busy;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_idx;
    logic [3:0]       r_anode;
    logic [6:0]       r_seg;
    logic             w_start;
    logic             w_neg;
    logic             w_hex_sel;
    logic [8:0]       w_mag;
    logic [11:0]      w_bcd;
    logic             w_bcd_done;

`ifdef DOUT_DISPLAY_HEX_EN
    assign w_hex_sel = bus.hex;
`else
    assign w_hex_sel = 1'b0;
`endif

    // Sign/magnitude split at capture; -128 yields 128
    always_comb begin
        w_neg = bus.sgn & bus.din[7] & ~w_hex_sel;
        if (w_neg) begin
            w_mag = 9'd256 - {1'b0, bus.din};
        end else begin
            w_mag = {1'b0, bus.din};
        end
    end

    // FSM next state and converter start
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.dval && w_hex_sel) begin
                    w_state_nxt = ST_DONE;
                end else if (bus.dval) begin
                    w_state_nxt = ST_SHIFT;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_step == 3'd7) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    dout_display_bin2bcd u_bin2bcd (
        .i_clk   (i_clock),
        .i_reset (i_reset),
        .i_start (w_start),
        .i_bin   (w_mag),
        .o_done  (w_bcd_done),
        .o_bcd   (w_bcd)
    );

    // Digit glyphs with leading-zero blanking; ones digit always shown
    always_comb begin
        w_result = {4{SEG_BLANK}};
        if (r_hex) begin
            w_result[1] = seg_of(r_din[7:4]);
            w_result[0] = seg_of(r_din[3:0]);
        end else begin
            w_result[3] = r_neg ? SEG_MINUS : SEG_BLANK;
            w_result[2] = (w_bcd[11:8] != 4'd0) ? seg_of(w_bcd[11:8]) : SEG_BLANK;
            w_result[1] = (w_bcd[11:4] != 8'd0) ? seg_of(w_bcd[7:4])  : SEG_BLANK;
            w_result[0] = seg_of(w_bcd[3:0]);
        end
    end

    // FSM state, capture registers and display registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_step  <= 3'd0;
            r_neg   <= 1'b0;
            r_hex   <= 1'b0;
            r_din   <= 8'd0;
            r_disp  <= {4{SEG_BLANK}};
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (bus.dval) begin
                        r_neg  <= w_neg;
                        r_hex  <= w_hex_sel;
                        r_din  <= bus.din;
                        r_step <= 3'd0;
                    end else begin
                        r_disp <= {4{SEG_BLANK}};
                    end
                end
                ST_SHIFT: r_step <= r_step + 3'd1;
                ST_DONE: begin
                    if (bus.dval && (w_bcd_done || r_hex)) begin
                        r_disp <= w_result;
                    end else begin
                        r_disp <= {4{SEG_BLANK}};
                    end
                end
                default: r_disp <= {4{SEG_BLANK}};
            endcase
        end
    end

    // Digit scan timing and registered anode/segment drive
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
            r_anode    <= 4'b1111;
            r_seg      <= SEG_BLANK;
        end else begin
            if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_anode <= ~(4'b0001 << r_idx);
            r_seg   <= r_disp[r_idx];
        end
    end

    assign bus.seg   = r_seg;
    assign bus.anode = r_anode;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_dout_display.sv
// Scoreboard bench for dout_display with a fast scan rate.
module tb_dout_display;
    localparam int SCAN_DIV = 4;
    localparam logic [6:0] S_BL = 7'h7F;
    localparam logic [6:0] S_MI = 7'h3F;
    localparam logic [6:0] S0   = 7'h40;
    localparam logic [6:0] S1   = 7'h79;
    localparam logic [6:0] S2   = 7'h24;
    localparam logic [6:0] S5   = 7'h12;
    localparam logic [6:0] S7   = 7'h78;
    localparam logic [6:0] S8   = 7'h00;
    localparam logic [6:0] SA   = 7'h08;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [27:0] exp_q[$];
    logic mon_active = 1'b0;

    dout_display_if bus();

    dout_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: each busy falling edge presents a result; scan all four digits and compare
    initial begin : monitor
        logic [27:0] exp;
        logic [6:0]  got [4];
        logic        prev;
        bit          seen;
        forever begin
            while (exp_q.size() == 0) @(negedge clk);
            mon_active = 1'b1;
            exp  = exp_q.pop_front();
            seen = 1'b0;
            prev = 1'b0;
            for (int i = 0; i < 60 && !seen; i++) begin
                @(negedge clk);
                if (prev && !bus.busy) seen = 1'b1;
                prev = bus.busy;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL sb_timeout got=no_busy_fall want=busy_fall");
            end else begin
                for (int d = 0; d < 4; d++) got[d] = 7'bx;
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    case (bus.anode)
                        4'b1110: got[0] = bus.seg;
                        4'b1101: got[1] = bus.seg;
                        4'b1011: got[2] = bus.seg;
                        4'b0111: got[3] = bus.seg;
                        default: ;
                    endcase
                end
                for (int d = 0; d < 4; d++)
                    check($sformatf("digit%0d", d), {25'd0, got[d]}, {25'd0, exp[d*7 +: 7]});
            end
            mon_active = 1'b0;
        end
    end

    task automatic run_vec(input string nm, input logic [7:0] din, input logic sgn,
                           input logic [27:0] exp, input int busy_len);
        int run   = 0;
        int gap   = 0;
        int phase = 0;
        exp_q.push_back(exp);
        bus.din  = din;
        bus.sgn  = sgn;
        bus.dval = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            case (phase)
                0: if (bus.busy) begin phase = 1; run = 1; end
                1: if (bus.busy) run++; else begin phase = 2; gap = 1; end
                2: if (!bus.busy) gap++; else phase = 3;
                default: ;
            endcase
        end
        check({nm, "_busy_len"}, run, busy_len);
        check({nm, "_gap"}, gap, 1);
        bus.dval = 1'b0;
        repeat (15) @(negedge clk);
    endtask

    initial begin : stimulus
        logic [3:0] want_an;
        bus.din  = 8'd0;
        bus.dval = 1'b0;
        bus.sgn  = 1'b0;
`ifdef DOUT_DISPLAY_HEX_EN
        bus.hex  = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",  bus.busy,  1'b0);
        check("rst_anode", bus.anode, 4'b1111);
        check("rst_seg",   bus.seg,   7'h7F);
        rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            want_an = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("anode_seq%0d", k), bus.anode, want_an);
        end

        run_vec("u200",  8'd200, 1'b0, {S_BL, S2,   S0,   S0}, 9);
        run_vec("s80",   8'h80,  1'b1, {S_MI, S1,   S2,   S8}, 9);
        run_vec("sFF",   8'hFF,  1'b1, {S_MI, S_BL, S_BL, S1}, 9);
        run_vec("u7",    8'd7,   1'b0, {S_BL, S_BL, S_BL, S7}, 9);
        run_vec("u0",    8'd0,   1'b0, {S_BL, S_BL, S_BL, S0}, 9);
        run_vec("u105",  8'd105, 1'b0, {S_BL, S1,   S0,   S5}, 9);
        run_vec("s7F",   8'h7F,  1'b1, {S_BL, S1,   S2,   S7}, 9);
        run_vec("u255",  8'hFF,  1'b0, {S_BL, S2,   S5,   S5}, 9);
        run_vec("sF6",   8'hF6,  1'b1, {S_MI, S_BL, S1,   S0}, 9);

        // Dval drops while a conversion of a displayed value is mid-shift
        bus.din  = 8'd200;
        bus.sgn  = 1'b0;
        bus.dval = 1'b1;
        repeat (25) @(negedge clk);
        check("drop_pre_busy", bus.busy, 1'b1);
        exp_q.push_back({4{S_BL}});
        @(negedge clk);
        bus.dval = 1'b0;
        repeat (40) @(negedge clk);

        // Reset mid-shift while a value is being displayed
        bus.dval = 1'b1;
        repeat (25) @(negedge clk);
        check("rstmid_pre_busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_busy",  bus.busy,  1'b0);
        check("rstmid_anode", bus.anode, 4'b1111);
        check("rstmid_seg",   bus.seg,   7'h7F);
        rst      = 1'b0;
        bus.dval = 1'b0;
        repeat (15) @(negedge clk);

`ifdef DOUT_DISPLAY_HEX_EN
        bus.hex = 1'b1;
        run_vec("hexA5", 8'hA5, 1'b1, {S_BL, S_BL, SA, S5}, 1);
        bus.hex = 1'b0;
`endif

        for (int i = 0; i < 200 && (exp_q.size() != 0 || mon_active); i++) @(negedge clk);
        if (exp_q.size() != 0 || mon_active) begin
            checks++;
            errors++;
            $display("FAIL drain got=pending want=empty");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
